// File: rtl/btn_event_arbiter_if.sv
// Event handshake bundle between the button arbiter and its consumer.
// master: drives evt_valid/evt_id, samples evt_ready; slave: the reverse.
interface btn_event_arbiter_if #(
    parameter int N_BTN = 4
) ();
    localparam int IW = $clog2(N_BTN);

    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_id;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );
endinterface

// File: rtl/btn_event_arbiter.sv
// Synchronizes, debounces and edge-captures N push buttons, then serves
// pending presses round-robin over a valid/ready handshake.
// Ports: clk, rst (async, active-high), btn_in (raw levels),
//   overrun_clr (clear sticky overrun), btn_level (debounced levels),
//   overrun (a press was lost), evt (master: evt_valid/evt_id/evt_ready).
module btn_event_arbiter #(
    parameter int N_BTN      = 4,
    parameter int TICK_DIV   = 50000,
    parameter int STABLE_CNT = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BTN-1:0]     btn_in,
    input  logic                 overrun_clr,
    output logic [N_BTN-1:0]     btn_level,
    output logic                 overrun,
    btn_event_arbiter_if.master  evt
);
    localparam int IW = $clog2(N_BTN);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    logic [N_BTN-1:0]      sync_a;
    logic [N_BTN-1:0]      sync_b;
    logic [TW-1:0]         tcnt;
    logic                  tick;
    logic [N_BTN-1:0][3:0] scnt;
    logic [N_BTN-1:0][3:0] scnt_next;
    logic [N_BTN-1:0]      level_next;
    logic [N_BTN-1:0]      rise;
    logic [N_BTN-1:0]      pending;
    logic [N_BTN-1:0]      grant;
    logic [N_BTN-1:0]      lost;
    logic [IW-1:0]         last_grant;
    logic [IW-1:0]         lg_next;
    logic [IW-1:0]         id_next;
    logic [IW-1:0]         cand;
    logic                  found;
    state_t                state;
    state_t                state_next;

    // Two-flop synchronizer per button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    // Shared sample-tick divider
    assign tick = (tcnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + TW'(1);
        end
    end

    // Debounce: a level is accepted after STABLE_CNT consecutive
    // differing samples; any agreeing sample restarts the count.
    always_comb begin
        level_next = btn_level;
        scnt_next  = scnt;
        rise       = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (tick) begin
                if (sync_b[i] == btn_level[i]) begin
                    scnt_next[i] = '0;
                end else if (scnt[i] + 4'd1 == 4'(STABLE_CNT)) begin
                    level_next[i] = sync_b[i];
                    scnt_next[i]  = '0;
                    rise[i]       = sync_b[i];
                end else begin
                    scnt_next[i] = scnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level <= '0;
            scnt      <= '0;
        end else begin
            btn_level <= level_next;
            scnt      <= scnt_next;
        end
    end

    // Scheduler: next state and round-robin winner search
    always_comb begin
        state_next = state;
        id_next    = evt.evt_id;
        lg_next    = last_grant;
        grant      = '0;
        found      = 1'b0;
        cand       = '0;
        case (state)
            IDLE: begin
                for (int k = 1; k <= N_BTN; k++) begin
                    cand = IW'((int'(last_grant) + k) % N_BTN);
                    if (!found && pending[cand]) begin
                        found       = 1'b1;
                        grant[cand] = 1'b1;
                        id_next     = cand;
                    end
                end
                if (found) begin
                    lg_next    = id_next;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (evt.evt_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            evt.evt_id <= '0;
            last_grant <= IW'(N_BTN - 1);
        end else begin
            state      <= state_next;
            evt.evt_id <= id_next;
            last_grant <= lg_next;
        end
    end

    assign evt.evt_valid = (state == PRESENT);

    // A new press beats a same-cycle grant clear; it only counts as lost
    // if the bit stays pending through this edge.
    assign lost = rise & pending & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | rise;
            if (|lost) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed and random checks of btn_event_arbiter against a
// rule-level reference model (TICK_DIV=4, STABLE_CNT=3, N_BTN=4).
module tb_btn_event_arbiter;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int SC = 3;

    logic       clk;
    logic       rst;
    logic [3:0] btn_in;
    logic       overrun_clr;
    logic [3:0] btn_level;
    logic       overrun;
    logic       rdy;

    btn_event_arbiter_if #(.N_BTN(N)) evt ();
    assign evt.evt_ready = rdy;

    btn_event_arbiter #(
        .N_BTN(N),
        .TICK_DIV(TD),
        .STABLE_CNT(SC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .overrun_clr(overrun_clr),
        .btn_level(btn_level),
        .overrun(overrun),
        .evt(evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    bit [3:0] m_in[$];
    int       ncyc;
    bit [3:0] m_lvl;
    int       m_sc[N];
    bit [3:0] m_pend;
    bit       m_ovr;
    bit       m_valid;
    int       m_id;
    int       m_lg;
    int       log_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_in    = {4'b0, 4'b0};
        ncyc    = 0;
        m_lvl   = '0;
        m_pend  = '0;
        m_ovr   = 0;
        m_valid = 0;
        m_id    = 0;
        m_lg    = N - 1;
        for (int i = 0; i < N; i++) m_sc[i] = 0;
    endtask

    task automatic model_update();
        bit [3:0] syn;
        bit [3:0] rise;
        bit [3:0] pre;
        bit       tick;
        bit       set;
        int       g;
        int       c;
        syn  = m_in[1];
        tick = (ncyc % TD) == TD - 1;
        rise = '0;
        pre  = m_pend;
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                if (syn[i] != m_lvl[i]) begin
                    m_sc[i]++;
                    if (m_sc[i] == SC) begin
                        m_lvl[i] = syn[i];
                        m_sc[i]  = 0;
                        rise[i]  = syn[i];
                    end
                end else begin
                    m_sc[i] = 0;
                end
            end
        end
        g = -1;
        if (!m_valid) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_lg + k) % N;
                if (g < 0 && pre[c]) g = c;
            end
            if (g >= 0) begin
                m_valid = 1;
                m_id    = g;
                m_lg    = g;
                m_pend[g] = 0;
            end
        end else if (rdy) begin
            m_valid = 0;
        end
        set = 0;
        for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
                if (pre[i] && i != g) set = 1;
                m_pend[i] = 1;
            end
        end
        if (set) m_ovr = 1;
        else if (overrun_clr) m_ovr = 0;
        m_in.push_front(btn_in);
        void'(m_in.pop_back());
        ncyc++;
    endtask

    task automatic step();
        if (!rst && evt.evt_valid === 1'b1 && rdy) log_q.push_back(int'(evt.evt_id));
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        @(negedge clk);
        chk("evt_valid", evt.evt_valid, m_valid);
        chk("evt_id", evt.evt_id, m_id);
        chk("btn_level", btn_level, m_lvl);
        chk("overrun", overrun, m_ovr);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_log(input string tag, input int exp[$]);
        chk({tag, "_count"}, log_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < log_q.size(); i++)
            chk({tag, "_id"}, log_q[i], exp[i]);
        log_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        run(3);
        rst = 1'b0;
    endtask

    initial begin
        int hold;
        rst         = 1'b1;
        btn_in      = 4'b1111;
        rdy         = 1'b1;
        overrun_clr = 1'b0;
        model_reset();

        // Reset with all buttons held, then four events in order
        @(negedge clk);
        chk("rst_valid", evt.evt_valid, 1'b0);
        chk("rst_level", btn_level, 4'b0000);
        chk("rst_ovr", overrun, 1'b0);
        run(3);
        rst = 1'b0;
        run(60);
        chk("all_level", btn_level, 4'b1111);
        chk_log("reset_seq", '{0, 1, 2, 3});
        btn_in = 4'b0000;
        run(30);
        chk_log("release_all", '{});

        // Clean press and release of button 1
        btn_in = 4'b0010;
        run(40);
        btn_in = 4'b0000;
        run(40);
        chk_log("clean", '{1});

        // Bouncing button 0 never settles
        for (int t = 0; t < 12; t++) begin
            btn_in[0] = ~btn_in[0];
            run(5);
        end
        btn_in = 4'b0000;
        run(30);
        chk("bounce_level", btn_level, 4'b0000);
        chk_log("bounce", '{});

        // Round-robin from a fresh reset
        do_reset();
        for (int r = 0; r < 2; r++) begin
            btn_in = 4'b0101;
            run(40);
            btn_in = 4'b0000;
            run(30);
        end
        chk_log("round_robin", '{0, 2, 0, 2});

        // Backpressure and overrun
        rdy    = 1'b0;
        btn_in = 4'b0001;
        run(30);
        chk("bp_valid", evt.evt_valid, 1'b1);
        btn_in = 4'b0011;
        run(25);
        chk("bp_ovr_first", overrun, 1'b0);
        btn_in = 4'b0001;
        run(25);
        btn_in = 4'b0011;
        run(25);
        chk("bp_ovr", overrun, 1'b1);
        chk("bp_id", evt.evt_id, 2'd0);
        rdy = 1'b1;
        run(20);
        btn_in = 4'b0000;
        run(30);
        chk_log("backpressure", '{0, 1});
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 1'b0);

        // Async reset while an event is presented
        rdy    = 1'b0;
        btn_in = 4'b0100;
        run(30);
        chk("mid_valid", evt.evt_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", evt.evt_valid, 1'b0);
        chk("async_level", btn_level, 4'b0000);
        model_reset();
        btn_in = 4'b0000;
        run(2);
        rst = 1'b0;
        rdy = 1'b1;
        run(40);
        chk_log("after_reset", '{});

        // Random buttons, ready and clear
        do_reset();
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                btn_in = 4'($urandom_range(0, 15));
                hold   = $urandom_range(1, 40);
            end
            hold--;
            rdy         = ($urandom_range(0, 3) != 0);
            overrun_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        log_q.delete();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Multi-button input controller for the board-level I/O path of the single-cycle RISC-V CPU. It synchronizes N raw push-button inputs, debounces them all using one shared sample-tick divider, and latches each debounced press (0→1) as a pending event. A round-robin scheduler then presents pending events one at a time over a valid/ready handshake to the consumer, such as single-step control or an MMIO input register. It replaces per-button debounce/edge-detect chains with one sequenced, shared resource.

## Interface
- N_BTN, 4, number of button inputs (2..16)
- TICK_DIV, 50000, clk cycles per debounce sample tick (≥2)
- STABLE_CNT, 3, consecutive differing samples required to accept a new level (1..15)

- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- btn_in  in  N_BTN  raw, asynchronous button levels
- evt_ready  in  1  consumer accepts the presented event
- overrun_clr  in  1  synchronous clear of overrun
- evt_valid  out  1  an event is presented
- evt_id  out  $clog2(N_BTN)  index of the presented button
- btn_level  out  N_BTN  debounced button levels
- overrun  out  1  sticky: a press was lost

## Operation
- Reset (async, rst=1) clears all state:
  - Sync flops, tick counter, stable counters, btn_level, pending, evt_valid, evt_id and overrun all become 0.
  - last_grant becomes N_BTN-1, so button 0 has first priority.
- Synchronizer: 2-FF chain per bit, reset 0. sync[i] is btn_in[i] delayed 2 clk.
- Tick divider: tcnt counts 0..TICK_DIV-1 and wraps to 0. tick=1 for exactly one cycle when tcnt==TICK_DIV-1. Period is exactly TICK_DIV cycles.
- Debounce, per button i, evaluated only on tick cycles:
  - If sync[i]==btn_level[i]: scnt[i] becomes 0.
  - Otherwise scnt[i] increments. When the incremented value equals STABLE_CNT, btn_level[i] becomes sync[i] and scnt[i] becomes 0.
  - scnt width is 4 bits and never exceeds STABLE_CNT.
- Press capture: on the clock edge where btn_level[i] goes 0→1, pending[i] is set. Release (1→0) produces no event.
- Overrun: a press capture on button i while pending[i] is already 1 sets overrun. The pending bit stays 1 (presses merge).
  - overrun_clr=1 clears overrun.
  - If a set and overrun_clr occur in the same cycle, the set wins.
- Scheduler FSM, two states:
  - IDLE (evt_valid=0): if pending is nonzero, choose the winner w. w is the first set bit searching upward from last_grant+1, wrapping modulo N_BTN. Then evt_id<=w, evt_valid<=1, pending[w]<=0, last_grant<=w, go to PRESENT.
  - PRESENT (evt_valid=1): evt_id is held stable. On evt_valid&evt_ready, evt_valid<=0 and the FSM returns to IDLE. Otherwise it stays.
- Simultaneous events:
  - If a new press on w arrives in the same cycle pending[w] is cleared by grant, the set wins and pending[w] stays 1. No overrun is flagged.
  - Several buttons accepted on the same tick are all captured and served in round-robin order.
- btn_level is a direct register output and is valid in every state.

## Timing
- btn_in change to sync: 2 clk.
- sync change to btn_level change: STABLE_CNT consecutive ticks with the differing value. The worst case is about (STABLE_CNT+1)·TICK_DIV clk.
- btn_level rise to pending set: same edge.
- pending set to evt_valid=1: 1 clk, when the FSM is in IDLE.
- Handshake accept to next evt_valid: at least 1 idle cycle (evt_valid low for ≥1 clk between events). Maximum throughput is 1 event per 2 clk.
- evt_id and evt_valid change only on clk edges, except on async reset.
- Async reset mid-PRESENT: evt_valid drops immediately and the event is lost. After deassertion, no event is produced until a fresh debounced press.

## Test plan
All scenarios use TICK_DIV=4, STABLE_CNT=3, N_BTN=4.
- Reset: assert rst with btn_in=4'b1111 → evt_valid=0, btn_level=0, overrun=0 throughout reset. After release, btn_level becomes 4'b1111 after 3 ticks, then events 0,1,2,3 are produced in order with evt_ready=1.
- Clean press: btn_in[1] 0→1 and held, evt_ready=1 → btn_level[1]=1 within 2+16 clk. evt_valid pulses 1 clk later with evt_id=1, exactly once. Releasing btn_in[1] produces no event.
- Bounce: toggle btn_in[0] every 5 clk for 60 clk, then hold 0 → btn_level[0] stays 0, evt_valid never asserts.
- Round-robin: press btn 0 and 2 together, evt_ready=1 → events id 0, then id 2 with one idle cycle between. Pressing 0 and 2 again gives 0 then 2 (last_grant=2 wraps to 3, 0).
- Backpressure/overrun: evt_ready=0 while btn0's event is presented. Press, release and press btn1 twice → evt_id stays 0 and stable, and overrun=1 after btn1's second press. Set evt_ready=1 → event 0, then a single event 1. overrun_clr=1 → overrun=0.
- Reset mid-handshake: async rst while evt_valid=1 → evt_valid=0 the same cycle without a clk edge. No residual event after release.
